// File: rtl/svo_stream_raster.sv
// svo_stream_raster: VGA raster generator that consumes an SVO pixel
// AXI-stream and locks its start-of-frame beat to raster position (0,0).
//
// Ports:
//   oclk, resetn (sync, active-low)   pixel clock and reset
//   in_axis_tvalid/tready/tdata/tuser  pixel stream, tuser marks frame start
//   vga_hsync, vga_vsync, vga_de       registered raster timing
//   vga_rgb                            registered pixel, 0 in blanking
//   locked                             high while the stream is aligned
//   frame_start                        pulse with displayed pixel (0,0)
//   underflow_cnt, resync_cnt          saturating event counters
//
// Build option: define SVO_RASTER_UNDERFLOW_MARK_EN to paint underflow and
// misaligned pixels magenta instead of black.
module svo_stream_raster #(
    parameter int BITS_PER_PIXEL = 12,
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter bit HSYNC_ACTIVE   = 1'b0,
    parameter bit VSYNC_ACTIVE   = 1'b0
) (
    input  logic                      oclk,
    input  logic                      resetn,
    input  logic                      in_axis_tvalid,
    output logic                      in_axis_tready,
    input  logic [BITS_PER_PIXEL-1:0] in_axis_tdata,
    input  logic                      in_axis_tuser,
    output logic                      vga_hsync,
    output logic                      vga_vsync,
    output logic                      vga_de,
    output logic [BITS_PER_PIXEL-1:0] vga_rgb,
    output logic                      locked,
    output logic                      frame_start,
    output logic [15:0]               underflow_cnt,
    output logic [7:0]                resync_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare count so the sync-end bound fits even with a zero back porch
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

`ifdef SVO_RASTER_UNDERFLOW_MARK_EN
    localparam int C = BITS_PER_PIXEL / 3;
    localparam logic [BITS_PER_PIXEL-1:0] FILL =
        {{C{1'b1}}, {C{1'b0}}, {C{1'b1}}};
`else
    localparam logic [BITS_PER_PIXEL-1:0] FILL = '0;
`endif

    typedef enum logic [1:0] {
        SYNC_WAIT,
        ALIGN,
        RUN
    } state_t;

    state_t state, state_n;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic act, at0, pop, under, resync, fs_n;
    logic [BITS_PER_PIXEL-1:0] rgb_n;

    assign act = (h < H_ACT) && (v < V_ACT);
    assign at0 = (h == '0) && (v == '0);
    assign pop = in_axis_tvalid && in_axis_tready;

    // Underflow wins over a tuser mismatch: with tvalid low there is no beat
    assign under  = (state == RUN) && act && !in_axis_tvalid;
    assign resync = (state == RUN) && act && in_axis_tvalid &&
                    ((in_axis_tuser && !at0) || (at0 && !in_axis_tuser));

    assign locked = (state == RUN);

    always_comb begin
        state_n        = state;
        in_axis_tready = 1'b0;
        if (resetn) begin
            unique case (state)
                SYNC_WAIT: begin
                    in_axis_tready = in_axis_tvalid && !in_axis_tuser;
                    if (in_axis_tvalid && in_axis_tuser)
                        state_n = ALIGN;
                end
                ALIGN: begin
                    in_axis_tready = at0;
                    if (at0 && in_axis_tvalid)
                        state_n = RUN;
                end
                RUN: begin
                    in_axis_tready = act &&
                        !(in_axis_tuser && !at0) &&
                        !(at0 && !in_axis_tuser);
                    if (resync)
                        state_n = SYNC_WAIT;
                end
                default: state_n = SYNC_WAIT;
            endcase
        end
    end

    // Beats discarded while hunting for SOF are never shown
    always_comb begin
        rgb_n = '0;
        fs_n  = 1'b0;
        if (act && state != SYNC_WAIT) begin
            if (pop) begin
                rgb_n = in_axis_tdata;
                fs_n  = at0;
            end else if (state == RUN) begin
                rgb_n = FILL;
            end
        end
    end

    always_ff @(posedge oclk) begin
        if (!resetn) begin
            state         <= SYNC_WAIT;
            h             <= '0;
            v             <= '0;
            vga_de        <= 1'b0;
            vga_rgb       <= '0;
            vga_hsync     <= ~HSYNC_ACTIVE;
            vga_vsync     <= ~VSYNC_ACTIVE;
            frame_start   <= 1'b0;
            underflow_cnt <= '0;
            resync_cnt    <= '0;
        end else begin
            state <= state_n;
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
            vga_de      <= act;
            vga_rgb     <= rgb_n;
            frame_start <= fs_n;
            vga_hsync   <= (h >= H_SS && h < H_SE) ?
                           HSYNC_ACTIVE : ~HSYNC_ACTIVE;
            vga_vsync   <= (v >= V_SS && v < V_SE) ?
                           VSYNC_ACTIVE : ~VSYNC_ACTIVE;
            if (under && underflow_cnt != '1)
                underflow_cnt <= underflow_cnt + 1'b1;
            if (resync && resync_cnt != '1)
                resync_cnt <= resync_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_svo_stream_raster.sv
// tb_svo_stream_raster: randomized stream against a frame-level model of
// the raster sink on a 14x7 raster with 8x4 active pixels.
module tb_svo_stream_raster;

    localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;

`ifdef SVO_RASTER_UNDERFLOW_MARK_EN
    localparam logic [11:0] FILL = 12'hF0F;
`else
    localparam logic [11:0] FILL = 12'h000;
`endif

    logic        oclk = 1'b0;
    logic        resetn = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [11:0] tdata = '0;
    logic        tuser = 1'b0;
    logic        hsync, vsync, de, lck, fstart;
    logic [11:0] rgb;
    logic [15:0] ufc;
    logic [7:0]  rsc;

    svo_stream_raster #(
        .BITS_PER_PIXEL(12),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0)
    ) dut (
        .oclk(oclk),
        .resetn(resetn),
        .in_axis_tvalid(tvalid),
        .in_axis_tready(tready),
        .in_axis_tdata(tdata),
        .in_axis_tuser(tuser),
        .vga_hsync(hsync),
        .vga_vsync(vsync),
        .vga_de(de),
        .vga_rgb(rgb),
        .locked(lck),
        .frame_start(fstart),
        .underflow_cnt(ufc),
        .resync_cnt(rsc)
    );

    always #5 oclk = ~oclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Beat queue: [13] drop-once marker, [12] tuser, [11:0] data
    logic [13:0] q[$];

    // Model: raster index since reset and the lock status of the stream
    int cyc;
    bit hunting_done;
    bit is_locked;
    int m_uf, m_rs;
    logic e_de, e_hs, e_vs, e_fs, e_lock;
    logic [11:0] e_rgb;

    task automatic model_reset();
        cyc = 0;
        hunting_done = 0;
        is_locked = 0;
        m_uf = 0;
        m_rs = 0;
        e_de = 0; e_rgb = '0; e_hs = 1; e_vs = 1; e_fs = 0; e_lock = 0;
    endtask

    task automatic push_frame(input int n, input bit idx, input int drop);
        for (int k = 0; k < n; k++)
            q.push_back({(k == drop), (k == 0), idx ? 12'(k) : 12'($urandom)});
    endtask

    task automatic push_garbage(input int n);
        for (int k = 0; k < n; k++)
            q.push_back({1'b0, 1'b0, 12'($urandom)});
    endtask

    task automatic cycle(input bit rst, input int gap_pct);
        int h, v;
        bit act, at0, rdy, pop, gap;
        @(negedge oclk);
        chk("de", de, e_de);
        chk("rgb", rgb, e_rgb);
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("frame_start", fstart, e_fs);
        chk("locked", lck, e_lock);
        chk("underflow_cnt", ufc, m_uf);
        chk("resync_cnt", rsc, m_rs);

        resetn = !rst;
        gap = (q.size() == 0) || ($urandom_range(99) < gap_pct);
        if (!gap && q[0][13]) begin
            gap = 1;
            q[0][13] = 1'b0;
        end
        if (gap) begin
            tvalid = 0;
            tuser  = 1'($urandom);
            tdata  = 12'($urandom);
        end else begin
            tvalid = 1;
            tuser  = q[0][12];
            tdata  = q[0][11:0];
        end
        #1;
        if (rst) begin
            chk("tready_rst", tready, 0);
            model_reset();
        end else begin
            h = cyc % HT;
            v = (cyc / HT) % VT;
            act = (h < HA) && (v < VA);
            at0 = (h == 0) && (v == 0);
            if (is_locked)
                rdy = act && (tuser == at0);
            else if (hunting_done)
                rdy = at0;
            else
                rdy = tvalid && !tuser;
            chk("tready", tready, rdy);
            pop = tvalid && rdy;

            e_de  = act;
            e_rgb = '0;
            e_fs  = 0;
            e_hs  = !(h >= HA + HFP && h < HA + HFP + HS);
            e_vs  = !(v >= VA + VFP && v < VA + VFP + VS);
            if (is_locked) begin
                if (act && !tvalid) begin
                    e_rgb = FILL;
                    if (m_uf < 65535) m_uf++;
                end else if (act && tuser != at0) begin
                    e_rgb = FILL;
                    if (m_rs < 255) m_rs++;
                    is_locked = 0;
                end else if (pop) begin
                    e_rgb = tdata;
                    e_fs  = at0;
                end
            end else if (hunting_done) begin
                if (pop) begin
                    e_rgb = tdata;
                    e_fs  = 1;
                    is_locked = 1;
                    hunting_done = 0;
                end
            end else if (tvalid && tuser) begin
                hunting_done = 1;
            end
            e_lock = is_locked;
            if (pop) void'(q.pop_front());
            cyc++;
        end
    endtask

    task automatic drain(input int budget, input int gap_pct);
        for (int i = 0; i < budget && q.size() > 0; i++)
            cycle(0, gap_pct);
        chk("drain", q.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge oclk);
        model_reset();

        // Idle raster with no stream
        cycle(1, 0);
        repeat (2 * FT) cycle(0, 0);

        // Garbage before SOF, then indexed frames back to back
        push_garbage(5);
        repeat (3) push_frame(32, 1, -1);
        drain(5 * FT, 0);

        // One dropped beat at index 10
        push_frame(32, 1, 10);
        push_frame(32, 1, -1);
        drain(4 * FT, 0);

        // Short frame (early SOF), long frame (missing SOF)
        push_frame(20, 1, -1);
        push_frame(32, 1, -1);
        push_frame(40, 1, -1);
        push_frame(32, 1, -1);
        push_frame(32, 1, -1);
        drain(10 * FT, 0);

        // Reset pulse mid-line while locked
        repeat (3) push_frame(32, 0, -1);
        repeat (FT + 20) cycle(0, 0);
        cycle(1, 0);
        drain(6 * FT, 0);

        // Random frame lengths, gaps and occasional resets
        for (int i = 0; i < 20 * FT; i++) begin
            if (q.size() < 40) begin
                case ($urandom_range(5))
                    0: push_frame(20, 0, -1);
                    1: push_frame(33, 0, -1);
                    2: push_garbage($urandom_range(1, 6));
                    default: push_frame(32, 0, -1);
                endcase
            end
            cycle($urandom_range(599) == 0, $urandom_range(6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/svo_stream_raster.md
# svo_stream_raster

Pixel-stream sink that consumes the SVO output AXI-stream (tdata/tuser start-of-frame) in the `oclk` domain. It generates VGA raster timing and pops exactly one pixel per active raster position. It aligns the stream's start-of-frame beat to raster position (0,0), outputs a fill colour on underflow, and re-locks after misalignment. It sits between the frame-buffer VDMA output and the board's VGA DAC/pins.

## Interface
Parameters:
- `BITS_PER_PIXEL`, default 12: pixel width; RGB444 packed as {R,G,B}.
- `H_ACTIVE`, default 640: active pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: horizontal sync width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_ACTIVE`, default 480: active lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vertical sync width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.
- `HSYNC_ACTIVE`, default 0: asserted level of `vga_hsync`.
- `VSYNC_ACTIVE`, default 0: asserted level of `vga_vsync`.

Ports:
- `oclk`  in  1  pixel clock.
- `resetn`  in  1  reset; synchronous, active-low.
- `in_axis_tvalid`  in  1  pixel beat valid.
- `in_axis_tready`  out  1  pixel beat accepted; combinational.
- `in_axis_tdata`  in  BITS_PER_PIXEL  pixel.
- `in_axis_tuser`  in  1  first pixel of frame.
- `vga_hsync`  out  1  registered horizontal sync.
- `vga_vsync`  out  1  registered vertical sync.
- `vga_de`  out  1  registered data enable.
- `vga_rgb`  out  BITS_PER_PIXEL  registered pixel; 0 whenever `vga_de`=0.
- `locked`  out  1  high while in RUN.
- `frame_start`  out  1  one-cycle pulse aligned with displayed pixel (0,0) of a locked frame.
- `underflow_cnt`  out  16  saturating count of underflow pixels.
- `resync_cnt`  out  8  saturating count of RUN→SYNC_WAIT exits.

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters: `h` runs 0..H_TOTAL-1 and wraps to 0. `v` increments when `h` wraps and itself wraps at V_TOTAL-1.
- Active region: `act` = (h < H_ACTIVE) && (v < V_ACTIVE).
- Sync: hsync is asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC. vsync is asserted for whole lines with V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC.
- Pop condition: `pop` = tvalid && tready. The raster free-runs from reset and never stalls on the stream.
- FSM states are SYNC_WAIT, ALIGN and RUN; the reset state is SYNC_WAIT.
- SYNC_WAIT:
  - tready = tvalid && !tuser, so non-SOF beats are discarded.
  - If tvalid && tuser, go to ALIGN without consuming the SOF beat.
- ALIGN:
  - tready = (h==0 && v==0).
  - At (0,0) the held SOF beat is popped, displayed, and the FSM goes to RUN.
- RUN:
  - tready = act && !(tuser && (h!=0 || v!=0)) && !(h==0 && v==0 && !tuser).
  - Underflow (act && !tvalid): display the fill colour and increment `underflow_cnt`. Stay in RUN.
  - Early SOF (act && tvalid && tuser && position ≠ (0,0)): display fill, no pop, go to SYNC_WAIT, increment `resync_cnt`.
  - Missing SOF (at (0,0), tvalid && !tuser): same response as early SOF.
  - If early SOF and underflow would both apply in one cycle, only the underflow applies, since tvalid=0 means there is no tuser to act on.
- Blanking (!act): tready=0 in RUN/ALIGN; `vga_rgb`=0.
- Counters saturate at all-ones and are cleared only by reset.

## Timing
- 1-cycle latency: the beat popped while the counters show (h,v) appears on `vga_rgb` the next cycle. That cycle has `vga_de`=1, and hsync/vsync are decoded from the same (h,v), so all outputs carry the same delay.
- `frame_start` is registered and goes high in the same cycle as `vga_de` for (0,0) when that pixel came from a popped SOF beat.
- Reset values:
  - h=0, v=0, FSM=SYNC_WAIT.
  - `vga_de`=0, `vga_rgb`=0.
  - `vga_hsync`=~HSYNC_ACTIVE, `vga_vsync`=~VSYNC_ACTIVE.
  - `locked`=0, `frame_start`=0, `underflow_cnt`=0, `resync_cnt`=0.
- Reset asserted mid-frame: everything returns to the reset values on the next edge. Stream beats are not popped while `resetn`=0 (tready=0).
- Worst-case source requirement: one beat per `oclk` cycle across an H_ACTIVE-long burst.

## Configuration
- `SVO_RASTER_UNDERFLOW_MARK_EN`:
  - Defined: the fill colour for underflow, early-SOF and missing-SOF pixels is magenta {all-ones R, zero G, all-ones B}, which is 12'hF0F at the default width.
  - Undefined: the fill colour is 0 (black).
- Counters and FSM behave identically in both builds.

## Test plan
All scenarios use a small raster: H_ACTIVE=8, H_FP=H_SYNC=H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 (V_TOTAL=7); 32 pixels per frame.
- Reset, no stream: `vga_hsync` asserted at h=10..11 (seen at the output one cycle later), `vga_vsync` asserted for line 5, `locked`=0, `vga_de` toggles, `vga_rgb`=0.
- Continuous valid frames of 32 beats with data=index and tuser on index 0: pixel k appears at raster (k%8, k/8). `frame_start` is high once per 98 cycles, `locked`=1, both counters stay 0.
- Garbage before SOF: 5 non-SOF beats then a frame. All 5 are popped immediately, the SOF beat is held until (0,0), and the first displayed pixel is 0.
- tvalid dropped for pixel index 10 only: that display slot shows the fill colour (0, or 12'hF0F with the macro), `underflow_cnt`=1, and the next pixel slot shows index 10.
- tuser on a 20-beat frame: the early SOF at raster index 20 is not popped, `resync_cnt`=1, `locked` drops, and lock is regained at the next (0,0) showing the new frame's pixel 0.
- Reset pulse mid-line while locked: outputs return to the reset values on the next edge, the FSM is SYNC_WAIT, and both counters are 0.
